// File: rtl/channel_ext_sink_fifo.sv
// Receive-side FIFO behind a channel ext port: enq strobes gated by a registered ready,
// first-word-fall-through valid/ready output, one-word skid margin and sticky overflow.
module channel_ext_sink_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] ext_data_in,
  input  logic                  ext_enq_in,
  output logic                  ext_ready_out,
  output logic [DATA_WIDTH-1:0] deq_data,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C     = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] READY_LIMIT = (ADDR_WIDTH+1)'(DEPTH - 2);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_valid;
  logic                  r_ready;
  logic                  r_overflow;

  logic                  w_deq;
  logic                  w_acc;
  logic [ADDR_WIDTH:0]   w_count_next;

  // A full FIFO still takes an enq when the head leaves in the same cycle.
  assign w_deq        = r_valid && deq_ready;
  assign w_acc        = ext_enq_in && ((r_count < DEPTH_C) || w_deq);
  assign w_count_next = r_count + (ADDR_WIDTH+1)'(w_acc) - (ADDR_WIDTH+1)'(w_deq);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_ready    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (ext_enq_in && !w_acc) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
      r_ready <= (w_count_next <= READY_LIMIT);
    end
  end

  // Storage is not cleared by reset, but reset still blocks the write.
  always_ff @(posedge CLK) begin
    if (RST && w_acc) begin
      r_mem[r_wr_ptr] <= ext_data_in;
    end
  end

  assign deq_data      = r_mem[r_rd_ptr];
  assign deq_valid     = r_valid;
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign ext_ready_out = r_ready;

endmodule
